// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC register, single-outstanding imem request, IF/ID buffer
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        imem_rsp_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush_ifid,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_next;
    logic        req_hs;
    logic        rsp_hs;
    logic        load;
    logic        consume;
    logic        unused_addr_bits;

    // Fetch addresses are word aligned; the low redirect bits carry no meaning here.
    assign unused_addr_bits = ^redirect_addr[1:0];

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        imem_req_valid = (state == REQ);
        imem_req_addr  = pc;
        imem_rsp_ready = 1'b0;
        flush_ifid     = redirect_valid;

        case (state)
            WAIT:    imem_rsp_ready = !if_valid || !stall;
            DROP:    imem_rsp_ready = 1'b1;
            default: imem_rsp_ready = 1'b0;
        endcase

        req_hs  = imem_req_valid && imem_req_ready;
        rsp_hs  = imem_rsp_valid && imem_rsp_ready;
        load    = (state == WAIT) && rsp_hs && !redirect_valid;
        consume = if_valid && !stall;

        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (req_hs) begin
                    // A redirect racing an accepted request leaves a stale response to drain.
                    state_next = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (rsp_hs) begin
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (rsp_hs) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_valid) begin
            pc_next = {redirect_addr[31:2], 2'b00};
        end else if (load) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= NOP_INSTR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            // Redirect outranks stall: a wrong-path instruction never survives in IF/ID.
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_ifid;
    logic [31:0] pc;

    int n_checks;
    int n_fail;
    int mem_lat;
    int cnt;
    logic        pend;
    logic [31:0] paddr;

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_ready (imem_rsp_ready),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .flush_ifid     (flush_ifid),
        .pc             (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: response mem_lat cycles after acceptance, data = addr + 0x1000_0000, held until taken.
    always @(posedge clk) begin
        if (rst) begin
            pend           <= 1'b0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
            paddr          <= 32'h0;
            cnt            <= 0;
        end else begin
            if (imem_rsp_valid && imem_rsp_ready) imem_rsp_valid <= 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                paddr <= imem_req_addr;
                if (mem_lat <= 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= imem_req_addr + 32'h1000_0000;
                end else begin
                    pend <= 1'b1;
                    cnt  <= mem_lat - 1;
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    pend           <= 1'b0;
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= paddr + 32'h1000_0000;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        mem_lat        = 1;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        // cycle 0: IDLE reset values
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_rsp_ready", imem_rsp_ready, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_flush", flush_ifid, 0);
        redirect_valid = 1'b1; #1;
        check("flush_follows", flush_ifid, 1);
        redirect_valid = 1'b0;
        // cycle 1: first request
        tick(); #1;
        check("c1_req_valid", imem_req_valid, 1);
        check("c1_req_addr", imem_req_addr, 32'h0);
        // cycle 2: WAIT
        tick(); #1;
        check("c2_req_valid", imem_req_valid, 0);
        check("c2_rsp_ready", imem_rsp_ready, 1);
        check("c2_if_instr_nop", if_instr, 32'h0000_0013);
        // cycle 3
        tick(); #1;
        check("c3_if_valid", if_valid, 1);
        check("c3_if_pc", if_pc, 32'h0);
        check("c3_if_instr", if_instr, 32'h1000_0000);
        check("c3_req_addr", imem_req_addr, 32'h4);
        // cycle 4
        tick(); #1;
        check("c4_if_valid", if_valid, 0);
        // cycle 5: stall asserted with 0x4 buffered
        tick(); stall = 1'b1; #1;
        check("c5_if_pc", if_pc, 32'h4);
        check("c5_req_addr", imem_req_addr, 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("stall_rsp_ready", imem_rsp_ready, 0);
            check("stall_rsp_pending", imem_rsp_valid, 1);
            check("stall_if_valid", if_valid, 1);
            check("stall_if_pc", if_pc, 32'h4);
            check("stall_if_instr", if_instr, 32'h1000_0004);
        end
        // cycle 9: release stall
        tick(); stall = 1'b0; #1;
        check("c9_rsp_ready", imem_rsp_ready, 1);
        // cycle 10
        tick(); #1;
        check("c10_if_pc", if_pc, 32'h8);
        check("c10_if_instr", if_instr, 32'h1000_0008);
        check("c10_req_addr", imem_req_addr, 32'hC);
        // cycles 11-12: fetch 0xC, request 0x10 with slow memory
        tick(); tick(); mem_lat = 3; #1;
        check("c12_if_pc", if_pc, 32'hC);
        check("c12_req_addr", imem_req_addr, 32'h10);
        // cycle 13: redirect in WAIT
        tick(); redirect_valid = 1'b1; redirect_addr = 32'h100; #1;
        check("wr_flush", flush_ifid, 1);
        check("wr_rsp_valid", imem_rsp_valid, 0);
        // cycle 14: DROP
        tick(); redirect_valid = 1'b0; mem_lat = 1; #1;
        check("wr_drop_rsp_ready", imem_rsp_ready, 1);
        check("wr_drop_req_valid", imem_req_valid, 0);
        check("wr_pc", pc, 32'h100);
        // cycle 15: stale response discarded
        tick(); #1;
        check("wr_stale_rsp", imem_rsp_valid, 1);
        // cycle 16
        tick(); #1;
        check("wr_req_addr", imem_req_addr, 32'h100);
        check("wr_if_valid", if_valid, 0);
        // cycle 18
        tick(); tick(); #1;
        check("c18_if_pc", if_pc, 32'h100);
        check("c18_if_instr", if_instr, 32'h1000_0100);
        stall = 1'b1; imem_req_ready = 1'b0;
        // cycle 19: redirect in REQ, unaligned target, stall high
        tick(); #1;
        check("c19_if_valid", if_valid, 1);
        redirect_valid = 1'b1; redirect_addr = 32'h203;
        // cycle 20
        tick(); redirect_valid = 1'b0; #1;
        check("rr_req_valid", imem_req_valid, 1);
        check("rr_req_addr", imem_req_addr, 32'h200);
        check("rr_if_valid", if_valid, 0);
        // cycle 21: request held stable while not ready
        tick(); #1;
        check("rr_addr_stable", imem_req_addr, 32'h200);
        stall = 1'b0; imem_req_ready = 1'b1;
        // cycle 23
        tick(); tick(); mem_lat = 4; #1;
        check("c23_if_pc", if_pc, 32'h200);
        check("c23_req_addr", imem_req_addr, 32'h204);
        // cycle 24: redirect in WAIT, then again in DROP
        tick(); redirect_valid = 1'b1; redirect_addr = 32'h40; #1;
        tick(); redirect_addr = 32'h80; #1;
        check("dr_drop_rsp_ready", imem_rsp_ready, 1);
        check("dr_drop_req_valid", imem_req_valid, 0);
        // cycle 26
        tick(); redirect_valid = 1'b0; mem_lat = 1; #1;
        check("dr_pc", pc, 32'h80);
        check("dr_still_drop", imem_req_valid, 0);
        // cycle 27: dropped response
        tick(); #1;
        check("dr_stale_rsp", imem_rsp_valid, 1);
        // cycle 28
        tick(); #1;
        check("dr_req_addr", imem_req_addr, 32'h80);
        check("dr_if_valid", if_valid, 0);
        // cycle 30
        tick(); tick(); mem_lat = 3; #1;
        check("c30_if_pc", if_pc, 32'h80);
        check("c30_if_instr", if_instr, 32'h1000_0080);
        // cycle 31: reset during WAIT
        tick(); rst = 1'b1; #1;
        check("c31_wait", imem_req_valid, 0);
        // cycle 32
        tick(); rst = 1'b0; mem_lat = 1; #1;
        check("mr_pc", pc, 32'h0);
        check("mr_if_valid", if_valid, 0);
        check("mr_req_valid", imem_req_valid, 0);
        check("mr_rsp_ready", imem_rsp_ready, 0);
        // cycle 33: redirect to top of address space with memory not ready
        tick(); #1;
        check("mr_req_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFE;
        // cycle 34
        tick(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
        check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        // cycle 36
        tick(); tick(); #1;
        check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_if_instr", if_instr, 32'h0FFF_FFFC);
        check("wrap_next_addr", imem_req_addr, 32'h0);
        check("wrap_pc", pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC-V pipeline. Owns the fetch PC register and issues one instruction-memory request at a time over a valid/ready handshake. Buffers the returned instruction toward IF/ID under the hazard stall, and applies redirects (taken branch, JAL, JALR) from the next-PC path. Outstanding responses are killed on a redirect, and IF/ID is flushed.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- NOP_INSTR, 32'h0000_0013, value of if_instr after reset (addi x0,x0,0)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  control-flow change resolved this cycle
- redirect_addr  in  32  new fetch target (selected next PC)
- stall  in  1  hazard hold; IF/ID does not consume this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (= pc)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction returned
- imem_rsp_data  in  32  instruction word
- imem_rsp_ready  out  1  controller accepts response
- if_valid  out  1  if_pc/if_instr hold an unconsumed instruction
- if_pc  out  32  PC of buffered instruction
- if_instr  out  32  buffered instruction
- flush_ifid  out  1  kill IF/ID contents
- pc  out  32  current fetch PC register

## Operation
- The FSM has four states: IDLE, REQ, WAIT and DROP. At most one request is outstanding.
- **Handshakes.**
  - A request handshake occurs when imem_req_valid & imem_req_ready.
  - A response handshake occurs when imem_rsp_valid & imem_rsp_ready.
  - Consume occurs when if_valid & !stall.
- **imem_req_valid** = (state==REQ). **imem_req_addr** = pc.
- **imem_rsp_ready**:
  - WAIT: !if_valid | !stall.
  - DROP: 1.
  - IDLE and REQ: 0.
- **Redirect.** Any redirect writes pc <= {redirect_addr[31:2],2'b00}.
- **IDLE**: lasts exactly one cycle after reset, then goes to REQ. A redirect in IDLE updates pc and still goes to REQ.
- **REQ**:
  - Redirect without handshake: stay in REQ with the new pc. This is the only case where the address changes while imem_req_valid is high and the request has not been accepted.
  - Redirect with handshake: go to DROP; the old-address request is in flight.
  - Handshake without redirect: go to WAIT.
- **WAIT**:
  - Response handshake without redirect: load if_pc <= pc, if_instr <= imem_rsp_data, if_valid <= 1, pc <= pc+4, go to REQ.
  - Redirect with response handshake in the same cycle: discard the data and go to REQ.
  - Redirect without response handshake: go to DROP.
- **DROP**:
  - Any response handshake discards the data and goes to REQ.
  - A redirect in DROP only updates pc; the state stays DROP unless a response handshake also occurs.
- **Output buffer (if_valid)**:
  - Priority is redirect, then load, then consume.
  - Redirect clears it: if_valid <= 0.
  - A load sets it.
  - A consume without a load clears it.
- **Redirect priority.** Redirect beats stall; a buffered instruction is dropped even while stall is high.
- **flush_ifid** = redirect_valid, combinational, in every state.
- **Arithmetic.** pc+4 wraps modulo 2^32. redirect_addr[1:0] is ignored.
- **Reset mid-operation.** Reset discards any outstanding request. The instruction memory shares rst. Responses arriving in IDLE/REQ are not accepted (imem_rsp_ready=0).

## Timing
- **Reset values**:
  - state=IDLE, pc=RESET_PC.
  - imem_req_valid=0, imem_rsp_ready=0.
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR.
  - flush_ifid follows redirect_valid.
- **First request.** rst is released before edge 0. IDLE in cycle 0, REQ in cycle 1 with addr RESET_PC.
- **Redirect latency.** redirect_valid in cycle N (REQ or WAIT without handshake) gives imem_req_addr = new target in cycle N+1 (REQ) or after the DROP drain.
- **Fetch latency.** Memory ready with 1-cycle response: request accepted in cycle R, response in R+1, if_valid=1 in R+2.
- **Throughput.** Steady state is one instruction per 2 cycles (REQ/WAIT alternation).
- **Stall.** With stall held and if_valid=1, if_* is held stable and imem_rsp_ready=0 in WAIT. The memory must hold rsp_valid/data until accepted.
- **Request stability.** imem_req_addr is stable while imem_req_valid & !imem_req_ready, except on redirect.

## Test plan
- **Reset and sequential fetch.** Reset; memory always ready, 1-cycle response, stall=0 → requests to 0x0, 0x4, 0x8. if_valid pulses with if_pc 0x0, 0x4, 0x8 every 2 cycles. if_instr=0x00000013 before the first load.
- **Stall hold.** if_valid=1 with if_pc 0x4; stall=1 for 3 cycles while the response for 0x8 is pending → imem_rsp_ready=0 and if_* unchanged for those 3 cycles. On stall=0, 0x8 loads on the next edge.
- **Redirect in WAIT.** Request for 0x10 outstanding; redirect_valid with redirect_addr=0x100; response 2 cycles later → flush_ifid=1 in the redirect cycle, state DROP, response discarded. The next request is addressed 0x100 and if_pc is never 0x10.
- **Redirect in REQ.** imem_req_ready=0, redirect_addr=0x203 → the next-cycle imem_req_addr is 0x200. If_valid is cleared even though stall=1.
- **Double redirect in DROP.** Redirect to 0x40, then redirect to 0x80 before the dropped response returns → one response discarded, next request 0x80.
- **Reset mid-operation and wrap.** Assert rst during WAIT → next cycle IDLE, pc=RESET_PC, if_valid=0. Separately, redirect to 0xFFFFFFFC, then fetch → next request addr 0x00000000.
